// File: rtl/pred_btb.sv
// Branch-target buffer with 2-bit direction counters, one-cycle registered prediction
// and push of taken targets into the buffer of predictions (BOP).
module pred_btb #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int ADDR_W  = 30
) (
   input  logic              s_clk_i,
   input  logic              s_reset_i,
   input  logic              s_flush_i,
   input  logic              s_look_i,
   input  logic [ADDR_W-1:0] s_look_addr_i,
   input  logic              s_bop_full_i,
   input  logic              s_upd_i,
   input  logic [ADDR_W-1:0] s_upd_addr_i,
   input  logic [ADDR_W-1:0] s_upd_target_i,
   input  logic              s_upd_taken_i,
   output logic              s_pred_valid_o,
   output logic              s_pred_taken_o,
   output logic [ADDR_W-1:0] s_pred_target_o,
   output logic              s_bop_push_o,
   output logic [ADDR_W-1:0] s_bop_data_o
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [ADDR_W-1:0] r_target [ENTRIES];
   logic [1:0]        r_ctr    [ENTRIES];

   logic              r_look_q;
   logic              r_taken_q;
   logic [ADDR_W-1:0] r_target_q;

   logic [IDX_W-1:0]  w_look_idx;
   logic [TAG_W-1:0]  w_look_tag;
   logic              w_look_hit;
   logic [IDX_W-1:0]  w_upd_idx;
   logic [TAG_W-1:0]  w_upd_tag;
   logic              w_upd_hit;

   assign w_look_idx = s_look_addr_i[IDX_W-1:0];
   assign w_look_tag = s_look_addr_i[IDX_W+TAG_W-1:IDX_W];
   assign w_look_hit = r_valid[w_look_idx] && (r_tag[w_look_idx] == w_look_tag);

   assign w_upd_idx  = s_upd_addr_i[IDX_W-1:0];
   assign w_upd_tag  = s_upd_addr_i[IDX_W+TAG_W-1:IDX_W];
   assign w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   // Address bits above the tag do not take part in the lookup.
   if (IDX_W + TAG_W < ADDR_W) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^{s_look_addr_i[ADDR_W-1:IDX_W+TAG_W],
                             s_upd_addr_i[ADDR_W-1:IDX_W+TAG_W]};
   end

   // Lookup reads pre-update contents; a lookup during flush is dropped.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         r_look_q   <= 1'b0;
         r_taken_q  <= 1'b0;
         r_target_q <= '0;
      end else begin
         r_look_q   <= s_look_i & ~s_flush_i;
         r_taken_q  <= w_look_hit & r_ctr[w_look_idx][1];
         r_target_q <= w_look_hit ? r_target[w_look_idx] : '0;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= 2'b00;
         end
      end else if (s_upd_i) begin
         if (w_upd_hit) begin
            if (s_upd_taken_i) begin
               if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
               r_target[w_upd_idx] <= s_upd_target_i;
            end else if (r_ctr[w_upd_idx] != 2'b00) begin
               r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
            end
         end else if (s_upd_taken_i) begin
            // Allocation starts weakly taken so one not-taken flips it.
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= s_upd_target_i;
            r_ctr[w_upd_idx]    <= 2'b10;
         end
      end
   end

   // A full BOP demotes a taken prediction; fetch simply continues sequentially.
   assign s_pred_valid_o  = r_look_q & ~s_flush_i;
   assign s_pred_taken_o  = s_pred_valid_o & r_taken_q & ~s_bop_full_i;
   assign s_bop_push_o    = s_pred_taken_o;
   assign s_pred_target_o = r_target_q;
   assign s_bop_data_o    = r_target_q;

endmodule

// File: tb/tb_pred_btb.sv
// Self-checking bench for pred_btb: directed vector table, a reset-in-flight
// sequence, then random traffic against a behavioural table model.
module tb_pred_btb;

   localparam int ENTRIES = 16;
   localparam int TAG_W   = 8;
   localparam int ADDR_W  = 30;

   logic              s_clk_i = 1'b0;
   logic              s_reset_i = 1'b1;
   logic              s_flush_i = 1'b0;
   logic              s_look_i = 1'b0;
   logic [ADDR_W-1:0] s_look_addr_i = '0;
   logic              s_bop_full_i = 1'b0;
   logic              s_upd_i = 1'b0;
   logic [ADDR_W-1:0] s_upd_addr_i = '0;
   logic [ADDR_W-1:0] s_upd_target_i = '0;
   logic              s_upd_taken_i = 1'b0;
   logic              s_pred_valid_o;
   logic              s_pred_taken_o;
   logic [ADDR_W-1:0] s_pred_target_o;
   logic              s_bop_push_o;
   logic [ADDR_W-1:0] s_bop_data_o;

   pred_btb #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
      .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_flush_i(s_flush_i),
      .s_look_i(s_look_i), .s_look_addr_i(s_look_addr_i), .s_bop_full_i(s_bop_full_i),
      .s_upd_i(s_upd_i), .s_upd_addr_i(s_upd_addr_i), .s_upd_target_i(s_upd_target_i),
      .s_upd_taken_i(s_upd_taken_i), .s_pred_valid_o(s_pred_valid_o),
      .s_pred_taken_o(s_pred_taken_o), .s_pred_target_o(s_pred_target_o),
      .s_bop_push_o(s_bop_push_o), .s_bop_data_o(s_bop_data_o)
   );

   always #5 s_clk_i = ~s_clk_i;

   typedef struct {
      bit rst, look, flush, full, upd, utaken;
      logic [ADDR_W-1:0] addr, uaddr, utgt;
      bit eValid, eTaken, chkTgt;
      logic [ADDR_W-1:0] eTgt;
   } vec_t;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: plain arrays of entry fields plus the pending prediction.
   bit mValid [ENTRIES];
   int mTag [ENTRIES];
   int mTarget [ENTRIES];
   int mCtr [ENTRIES];
   bit pLook = 0, pTaken = 0;
   int pTarget = 0;

   bit aValid, aTaken, aPush;
   logic [ADDR_W-1:0] aTgt, aData;
   bit eValid, eTaken;
   int eTgt;

   function automatic vec_t mk(bit look, int addr, bit flush, bit full,
                               bit upd, int uaddr, int utgt, bit utaken,
                               bit ev, bit et, bit chk, int etgt);
      vec_t v;
      v.rst = 0; v.look = look; v.addr = addr[ADDR_W-1:0]; v.flush = flush; v.full = full;
      v.upd = upd; v.uaddr = uaddr[ADDR_W-1:0]; v.utgt = utgt[ADDR_W-1:0]; v.utaken = utaken;
      v.eValid = ev; v.eTaken = et; v.chkTgt = chk; v.eTgt = etgt[ADDR_W-1:0];
      return v;
   endfunction

   function automatic void modelStep(vec_t v);
      int li, lt, ui, ut;
      bit lhit, uhit;
      if (v.rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 0; mCtr[i] = 0;
         end
         pLook = 0; pTaken = 0; pTarget = 0;
         return;
      end
      li = int'(v.addr) % ENTRIES;
      lt = (int'(v.addr) / ENTRIES) % (1 << TAG_W);
      lhit = mValid[li] && mTag[li] == lt;
      pLook = v.look && !v.flush;
      pTaken = lhit && mCtr[li] >= 2;
      pTarget = lhit ? mTarget[li] : 0;
      if (v.upd) begin
         ui = int'(v.uaddr) % ENTRIES;
         ut = (int'(v.uaddr) / ENTRIES) % (1 << TAG_W);
         uhit = mValid[ui] && mTag[ui] == ut;
         if (uhit && v.utaken) begin
            mCtr[ui] = (mCtr[ui] == 3) ? 3 : mCtr[ui] + 1;
            mTarget[ui] = int'(v.utgt);
         end else if (uhit) begin
            mCtr[ui] = (mCtr[ui] == 0) ? 0 : mCtr[ui] - 1;
         end else if (v.utaken) begin
            mValid[ui] = 1; mTag[ui] = ut; mTarget[ui] = int'(v.utgt); mCtr[ui] = 2;
         end
      end
   endfunction

   // One clock: drive at negedge, sample outputs 1ns later, advance model at posedge.
   task automatic applyStimulus(vec_t v);
      @(negedge s_clk_i);
      s_reset_i = v.rst; s_look_i = v.look; s_look_addr_i = v.addr;
      s_flush_i = v.flush; s_bop_full_i = v.full; s_upd_i = v.upd;
      s_upd_addr_i = v.uaddr; s_upd_target_i = v.utgt; s_upd_taken_i = v.utaken;
      #1;
      aValid = s_pred_valid_o; aTaken = s_pred_taken_o; aPush = s_bop_push_o;
      aTgt = s_pred_target_o; aData = s_bop_data_o;
      eValid = pLook && !v.flush;
      eTaken = eValid && pTaken && !v.full;
      eTgt = pTarget;
      @(posedge s_clk_i);
      modelStep(v);
   endtask

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkVec(string tag, bit ev, bit et, bit chk, logic [ADDR_W-1:0] etgt);
      checkOutput({tag, " valid"}, 32'(aValid), 32'(ev));
      checkOutput({tag, " taken"}, 32'(aTaken), 32'(et));
      checkOutput({tag, " push"}, 32'(aPush), 32'(et));
      if (chk) begin
         checkOutput({tag, " target"}, 32'(aTgt), 32'(etgt));
         checkOutput({tag, " data"}, 32'(aData), 32'(etgt));
      end
   endtask

   vec_t vq[$];
   vec_t v;

   initial begin
      // Two reset cycles, outputs not examined until reset has been seen.
      v = mk(0,0,0,0, 0,0,0,0, 0,0,0,0);
      v.rst = 1;
      applyStimulus(v);
      applyStimulus(v);

      //          look addr  fl fu  upd uaddr utgt  tk   eV eT chk eTgt
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 0,0,1,'h000));
      vq.push_back(mk(1,'h040,0,0, 0,'h000,'h000,0, 0,0,1,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,0,1,'h000));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,1, 0,0,0,'h000));
      vq.push_back(mk(1,'h040,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h140,0,0, 0,'h000,'h000,0, 1,1,1,'h100));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h000,0, 1,0,1,'h000));
      vq.push_back(mk(1,'h040,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,0,1,'h100));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,1, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,1, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,1, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h040,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,0, 1,1,1,'h100));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 1,'h040,'h100,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h040,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,0,1,'h100));
      vq.push_back(mk(0,'h000,0,0, 1,'h085,'h3AB,1, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,1, 0,'h000,'h000,0, 1,0,1,'h3AB));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,1,1,'h3AB));
      vq.push_back(mk(1,'h085,1,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,1,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,1,0, 1,'h085,'h3AB,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,0,1,'h3AB));
      vq.push_back(mk(1,'h085,0,0, 1,'h085,'h3AB,1, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,0, 0,'h000,'h000,0, 1,0,1,'h3AB));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,1,1,'h3AB));
      vq.push_back(mk(0,'h000,0,0, 1,'h085,'h111,1, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,1,1,'h111));
      vq.push_back(mk(0,'h000,0,0, 1,'h185,'h999,0, 0,0,0,'h000));
      vq.push_back(mk(1,'h085,0,0, 0,'h000,'h000,0, 0,0,0,'h000));
      vq.push_back(mk(0,'h000,0,0, 0,'h000,'h000,0, 1,1,1,'h111));

      foreach (vq[i]) begin
         applyStimulus(vq[i]);
         checkVec($sformatf("row%0d", i), vq[i].eValid, vq[i].eTaken, vq[i].chkTgt, vq[i].eTgt);
      end

      // Reset while a lookup of a freshly allocated entry is in flight;
      // the update issued in the reset cycle must also be ignored.
      applyStimulus(mk(0,'h000,0,0, 1,'h2C7,'h055,1, 0,0,0,0));
      applyStimulus(mk(1,'h2C7,0,0, 0,'h000,'h000,0, 0,0,0,0));
      v = mk(1,'h2C7,0,0, 1,'h040,'h077,1, 0,0,0,0);
      v.rst = 1;
      applyStimulus(v);
      applyStimulus(mk(1,'h2C7,0,0, 0,'h000,'h000,0, 0,0,0,0));
      checkVec("rst_out", 0, 0, 1, '0);
      applyStimulus(mk(1,'h040,0,0, 0,'h000,'h000,0, 0,0,0,0));
      checkVec("rst_miss_alloc", 1, 0, 1, '0);
      applyStimulus(mk(0,'h000,0,0, 0,'h000,'h000,0, 0,0,0,0));
      checkVec("rst_miss_upd", 1, 0, 1, '0);

      // Random traffic over a small index/tag space so hits are frequent.
      for (int n = 0; n < 600; n++) begin
         int a, u;
         a = int'($urandom_range(0, 63)) | (int'($urandom_range(0, 7)) << 20);
         u = int'($urandom_range(0, 63)) | (int'($urandom_range(0, 7)) << 20);
         v = mk($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, u,
                int'($urandom_range(0, 'h3FFF)), $urandom_range(0, 9) < 6, 0,0,0,0);
         v.rst = ($urandom_range(0, 99) == 0);
         applyStimulus(v);
         checkVec($sformatf("rand%0d", n), eValid, eTaken, eValid, eTgt[ADDR_W-1:0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
